// File: rtl/uart_param_receiver_pkg.sv
// Shared UART receiver definitions: FSM state encodings, parity modes and
// the expected-parity helper used by the receiver datapath.
package uart_param_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_BIT  = 3'd1,
    ST_DATA_BITS  = 3'd2,
    ST_PARITY_BIT = 3'd3,
    ST_STOP_BITS  = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Value the parity bit must carry for a given XOR of the data bits.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_param_receiver_line_conditioner.sv
// Rx line conditioner: two-flop synchroniser plus a saturating count of
// consecutive high samples, used to qualify start edges.
module uart_line_conditioner #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic in_sample_o,
  output logic hold_ok_o
);

  localparam int HOLD_MAX = OVERSAMPLE / 4;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);

  logic          sync1_q, sync2_q;
  logic [HW-1:0] hold_q, hold_d;

  // Count high samples, restart on a low one, stick at the threshold.
  always_comb begin
    hold_d = hold_q;
    if (!sync2_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_SAT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Synchroniser and hold counter; reset looks like a long-idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hold_q  <= HOLD_SAT;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      hold_q  <= hold_d;
    end
  end

  assign in_sample_o = sync2_q;
  assign hold_ok_o   = (hold_q == HOLD_SAT);

endmodule

// File: rtl/uart_param_receiver.sv
// Parameterised oversampling UART receiver with a one-entry output buffer.
// Status outputs are registered one-clock pulses.
module uart_param_receiver
  import uart_param_receiver_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_START_END = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST      = BW'(STOP_BITS - 1);

  logic in_sample, hold_ok;

  uart_line_conditioner #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_cond (
    .clk        (clk),
    .rst        (rst),
    .line_i     (in),
    .in_sample_o(in_sample),
    .hold_ok_o  (hold_ok)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_good;
  logic                 consume;

  assign consume = out_valid_q & out_ready;

  // Frame FSM: start qualification, mid-bit sampling, parity and stop checks.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    perr_d     = 1'b0;
    frame_good = 1'b0;
    case (state_q)
      ST_IDLE, ST_BREAK_WAIT: begin
        tick_d = '0;
        bit_d  = '0;
        busy_d = 1'b0;
        // Leaving BREAK_WAIT acts as IDLE on the same tick, so a start edge
        // that arrives exactly when the line has recovered is not lost.
        if (state_q == ST_IDLE || hold_ok) begin
          state_d = ST_IDLE;
          if (!in_sample) begin
            if (hold_ok) begin
              state_d   = ST_START_BIT;
              tick_d    = TW'(1);
              par_bad_d = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_START_BIT: begin
        if (in_sample) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_START_END) begin
          state_d = ST_DATA_BITS;
          tick_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA_BITS: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TICK_LAST) begin
          shift_d = {in_sample, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY_BIT : ST_STOP_BITS;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY_BIT: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TICK_LAST) begin
          par_bad_d = (in_sample != parity_bit(^shift_q, PARITY));
          state_d   = ST_STOP_BITS;
          bit_d     = '0;
        end
      end
      ST_STOP_BITS: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TICK_LAST) begin
          if (!in_sample) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_BREAK_WAIT;
            tick_d  = '0;
            bit_d   = '0;
          end else if (bit_q == STOP_LAST) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              frame_good = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
    if (!en) begin
      state_d    = ST_IDLE;
      tick_d     = '0;
      bit_d      = '0;
      busy_d     = 1'b0;
      err_d      = 1'b0;
      perr_d     = 1'b0;
      frame_good = 1'b0;
    end
  end

  // Output buffer: load on a good frame if empty (or emptying), else overrun.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovr_d       = 1'b0;
    done_d      = frame_good;
    if (en) begin
      if (frame_good) begin
        if (!out_valid_q || consume) begin
          out_d       = shift_q;
          out_valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (consume) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      par_bad_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      par_bad_q   <= par_bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      perr_q      <= perr_d;
      ovr_q       <= ovr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Receive shift register holds frame data only and needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign out_valid  = out_valid_q;
  assign out        = out_q;

endmodule
